// File: rtl/stack_access_controller_if.sv
// Data-memory port of the stack access controller.
// Single-word request with a ready handshake.
interface stack_access_controller_if #(
  parameter int Width = 32
);
  logic [Width-1:0] MemAddr;
  logic [Width-1:0] MemWData;
  logic             MemWrite;
  logic             MemRead;
  logic [Width-1:0] MemRData;
  logic             MemReady;

  modport master (
    output MemAddr,
    output MemWData,
    output MemWrite,
    output MemRead,
    input  MemRData,
    input  MemReady
  );

  modport slave (
    input  MemAddr,
    input  MemWData,
    input  MemWrite,
    input  MemRead,
    output MemRData,
    output MemReady
  );
endinterface

// File: rtl/stack_access_controller.sv
// Full-descending stack push/pop sequencer with SP write-back.
// Define STACK_WATERMARK_EN to add MinSP/DepthMax tracking.
module stack_access_controller #(
  parameter int               Width      = 32,
  parameter logic [Width-1:0] StackBase  = 32'h00000AF0,
  parameter logic [Width-1:0] StackLimit = 32'h00000A00,
  parameter int               WordBytes  = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PushReq,
  input  logic             PopReq,
  input  logic [Width-1:0] PushData,
  output logic             ReqReady,
  output logic             Done,
  output logic             Error,
  output logic [Width-1:0] PopData,
  input  logic [Width-1:0] SPCurrent,
  output logic             SPWrite,
  output logic [Width-1:0] SPNext,
  stack_access_controller_if.master Mem
`ifdef STACK_WATERMARK_EN
  ,
  output logic [Width-1:0] MinSP,
  output logic [Width-1:0] DepthMax
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PUSH_WR,
    POP_RD,
    FINISH
  } state_t;

  localparam logic [Width-1:0] Step = Width'(WordBytes);

  state_t           state, state_d;
  logic [Width-1:0] addr_q;
  logic [Width-1:0] wdata_q;
  logic [Width-1:0] spnext_q;
  logic [Width-1:0] popdata_q;
  logic             spw_q;
  logic             err_q;

  logic [Width-1:0] push_addr;
  logic             ovf;
  logic             udf;

  assign push_addr = SPCurrent - Step;
  // SP below one word would wrap the subtraction.
  assign ovf = (SPCurrent < Step) || (push_addr < StackLimit);
  assign udf = (SPCurrent >= StackBase);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (PushReq)     state_d = ovf ? FINISH : PUSH_WR;
        else if (PopReq) state_d = udf ? FINISH : POP_RD;
      end
      PUSH_WR: if (Mem.MemReady) state_d = FINISH;
      POP_RD:  if (Mem.MemReady) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      spnext_q  <= '0;
      popdata_q <= '0;
      spw_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      spw_q <= 1'b0;
      case (state)
        IDLE: begin
          if (PushReq) begin
            err_q <= ovf;
            if (!ovf) begin
              addr_q  <= push_addr;
              wdata_q <= PushData;
            end
          end else if (PopReq) begin
            err_q <= udf;
            if (!udf) begin
              addr_q   <= SPCurrent;
              spnext_q <= SPCurrent + Step;
            end
          end
        end
        PUSH_WR: begin
          if (Mem.MemReady) begin
            spnext_q <= addr_q;
            spw_q    <= 1'b1;
          end
        end
        POP_RD: begin
          if (Mem.MemReady) begin
            popdata_q <= Mem.MemRData;
            spw_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so a reset drops them at once.
  assign ReqReady     = (state == IDLE);
  assign Done         = (state == FINISH);
  assign Error        = err_q && (state == FINISH);
  assign SPWrite      = spw_q;
  assign SPNext       = spnext_q;
  assign PopData      = popdata_q;
  assign Mem.MemAddr  = addr_q;
  assign Mem.MemWData = wdata_q;
  assign Mem.MemWrite = (state == PUSH_WR);
  assign Mem.MemRead  = (state == POP_RD);

`ifdef STACK_WATERMARK_EN
  logic [Width-1:0] min_sp_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      min_sp_q <= StackBase;
    end else if (state == PUSH_WR && Mem.MemReady) begin
      if (addr_q < min_sp_q) min_sp_q <= addr_q;
    end
  end

  assign MinSP    = min_sp_q;
  assign DepthMax = (StackBase - min_sp_q) / Step;
`endif

endmodule

// File: tb/tb_stack_access_controller.sv
// Scoreboard bench for stack_access_controller.
// Directed push/pop vectors; a monitor checks each Done.
module tb_stack_access_controller;

  typedef struct {
    logic        err;
    logic        spw;
    logic [31:0] spn;
    logic [31:0] pdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          wr;
    int          rd;
    int          t0;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PushReq = 1'b0;
  logic        PopReq = 1'b0;
  logic [31:0] PushData = '0;
  logic        ReqReady;
  logic        Done;
  logic        Error;
  logic [31:0] PopData;
  logic [31:0] SPCurrent = 32'h00000AF0;
  logic        SPWrite;
  logic [31:0] SPNext;
`ifdef STACK_WATERMARK_EN
  logic [31:0] MinSP;
  logic [31:0] DepthMax;
`endif

  stack_access_controller_if #(.Width(32)) mem ();

  stack_access_controller dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .PushReq  (PushReq),
    .PopReq   (PopReq),
    .PushData (PushData),
    .ReqReady (ReqReady),
    .Done     (Done),
    .Error    (Error),
    .PopData  (PopData),
    .SPCurrent(SPCurrent),
    .SPWrite  (SPWrite),
    .SPNext   (SPNext),
    .Mem      (mem)
`ifdef STACK_WATERMARK_EN
    ,
    .MinSP    (MinSP),
    .DepthMax (DepthMax)
`endif
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   issued = 0;
  int   mem_waits = 0;
  exp_t expq[$];

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic err, input logic spw,
                              input logic [31:0] spn, pdata,
                              input logic [31:0] addr, wdata,
                              input int lat, wr, rd);
    exp_t e;
    e.err = err; e.spw = spw; e.spn = spn; e.pdata = pdata;
    e.addr = addr; e.wdata = wdata;
    e.lat = lat; e.wr = wr; e.rd = rd; e.t0 = 0;
    return e;
  endfunction

  // Memory model: MemReady after mem_waits stall cycles.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    mem.MemReady = 1'b0;
    mem.MemRData = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (mem.MemWrite || mem.MemRead) begin
        mem.MemReady = (wcnt >= mem_waits);
        wcnt++;
      end else begin
        mem.MemReady = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    int          wr_cyc, rd_cyc;
    logic        both, prev_done;
    logic [31:0] wr_addr, wr_data, rd_addr;
    wr_cyc = 0; rd_cyc = 0; both = 0; prev_done = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    forever begin
      @(negedge CLK);
      if (!Reset) begin
        wr_cyc = 0; rd_cyc = 0; both = 0; prev_done = 0;
        continue;
      end
      if (mem.MemWrite && mem.MemRead) both = 1;
      if (mem.MemWrite) wr_cyc++;
      if (mem.MemRead) rd_cyc++;
      if (mem.MemWrite && mem.MemReady) begin
        wr_addr = mem.MemAddr;
        wr_data = mem.MemWData;
      end
      if (mem.MemRead && mem.MemReady) rd_addr = mem.MemAddr;
      if (prev_done) chk("done_pulse", {31'd0, Done}, 32'd0);
      prev_done = Done;
      if (Done) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got Done=1, expected none");
        end else begin
          e = expq.pop_front();
          chk("error", {31'd0, Error}, {31'd0, e.err});
          chk("spwrite", {31'd0, SPWrite}, {31'd0, e.spw});
          if (e.spw) chk("spnext", SPNext, e.spn);
          chk("popdata", PopData, e.pdata);
          chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
          chk("wr_cycles", 32'(wr_cyc), 32'(e.wr));
          chk("rd_cycles", 32'(rd_cyc), 32'(e.rd));
          chk("strobes_both", {31'd0, both}, 32'd0);
          if (e.wr > 0) begin
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.wdata);
          end
          if (e.rd > 0) chk("rd_addr", rd_addr, e.addr);
          n_done++;
        end
        wr_cyc = 0; rd_cyc = 0; both = 0;
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 100 && n_done < issued; i++) @(negedge CLK);
    if (n_done < issued) begin
      n_checks++;
      $display("FAIL timeout: got %0d dones, expected %0d",
               n_done, issued);
      expq.delete();
      n_done = issued;
    end
  endtask

  task automatic req(input logic push, pop,
                     input logic [31:0] sp, data, rdata,
                     input int waits, input exp_t e);
    @(negedge CLK);
    mem_waits = waits;
    mem.MemRData = rdata;
    SPCurrent = sp;
    PushData = data;
    PushReq = push;
    PopReq = pop;
    e.t0 = cyc;
    expq.push_back(e);
    issued++;
    @(posedge CLK);
    #1;
    PushReq = 1'b0;
    PopReq = 1'b0;
    wait_done();
  endtask

  initial begin : stim
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_reqready", {31'd0, ReqReady}, 32'd1);
    chk("rst_strobes",
        {27'd0, Done, Error, SPWrite, mem.MemWrite, mem.MemRead},
        32'd0);
    chk("rst_spnext", SPNext, 32'd0);
    chk("rst_memaddr", mem.MemAddr, 32'd0);
    chk("rst_wdata", mem.MemWData, 32'd0);
    chk("rst_popdata", PopData, 32'd0);
`ifdef STACK_WATERMARK_EN
    chk("rst_minsp", MinSP, 32'h00000AF0);
`endif
    Reset = 1'b1;

    req(1, 0, 32'h0AF0, 32'hDEADBEEF, 0, 0,
        mk(0, 1, 32'h0AEC, 0, 32'h0AEC, 32'hDEADBEEF, 3, 1, 0));
    req(0, 1, 32'h0AEC, 0, 32'h12345678, 2,
        mk(0, 1, 32'h0AF0, 32'h12345678, 32'h0AEC, 0, 5, 0, 3));
    req(0, 1, 32'h0AF0, 0, 32'hFFFFFFFF, 0,
        mk(1, 0, 0, 32'h12345678, 0, 0, 2, 0, 0));
    req(1, 0, 32'h0A00, 32'h00000001, 0, 0,
        mk(1, 0, 0, 32'h12345678, 0, 0, 2, 0, 0));
    req(1, 0, 32'h0A04, 32'hCAFE0001, 0, 0,
        mk(0, 1, 32'h0A00, 32'h12345678, 32'h0A00,
           32'hCAFE0001, 3, 1, 0));
    req(1, 1, 32'h0AF0, 32'h55AA55AA, 32'h99999999, 1,
        mk(0, 1, 32'h0AEC, 32'h12345678, 32'h0AEC,
           32'h55AA55AA, 4, 2, 0));
    req(1, 0, 32'h0002, 32'h77777777, 0, 0,
        mk(1, 0, 0, 32'h12345678, 0, 0, 2, 0, 0));
    req(0, 1, 32'h0AEC, 0, 32'h0BADF00D, 0,
        mk(0, 1, 32'h0AF0, 32'h0BADF00D, 32'h0AEC, 0, 3, 0, 1));

    // Abort a stalled push with reset.
    @(negedge CLK);
    mem_waits = 50;
    SPCurrent = 32'h0AF0;
    PushData = 32'h13579BDF;
    PushReq = 1'b1;
    @(posedge CLK);
    #1;
    PushReq = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    chk("stall_memwrite", {31'd0, mem.MemWrite}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("abort_memwrite", {31'd0, mem.MemWrite}, 32'd0);
    chk("abort_reqready", {31'd0, ReqReady}, 32'd1);
    chk("abort_spwrite", {31'd0, SPWrite}, 32'd0);
    @(negedge CLK);
    chk("abort_spwrite2", {31'd0, SPWrite}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    Reset = 1'b1;

    req(1, 0, 32'h0AF0, 32'h000000A1, 0, 0,
        mk(0, 1, 32'h0AEC, 0, 32'h0AEC, 32'h000000A1, 3, 1, 0));
    req(1, 0, 32'h0AEC, 32'h000000A2, 0, 0,
        mk(0, 1, 32'h0AE8, 0, 32'h0AE8, 32'h000000A2, 3, 1, 0));
    req(1, 0, 32'h0AE8, 32'h000000A3, 0, 0,
        mk(0, 1, 32'h0AE4, 0, 32'h0AE4, 32'h000000A3, 3, 1, 0));
    req(0, 1, 32'h0AE4, 0, 32'h11111111, 0,
        mk(0, 1, 32'h0AE8, 32'h11111111, 32'h0AE4, 0, 3, 0, 1));
    req(0, 1, 32'h0AE8, 0, 32'h22222222, 1,
        mk(0, 1, 32'h0AEC, 32'h22222222, 32'h0AE8, 0, 4, 0, 2));
`ifdef STACK_WATERMARK_EN
    @(negedge CLK);
    chk("minsp", MinSP, 32'h00000AE4);
    chk("depthmax", DepthMax, 32'd3);
`endif

    repeat (5) @(negedge CLK);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_access_controller.md
Name: stack_access_controller

Overview:
- Drives the stack pointer register and sequences push/pop data-memory transactions for the processor.
- Takes push/pop requests from the control unit and reads the current stack pointer value.
- Performs the memory write or read through a ready-handshake, then writes the updated stack pointer back through the register's enable/data inputs.
- The stack is full-descending: push pre-decrements, pop post-increments.

Parameters:
- Width, 32, data, address and stack pointer width.
- StackBase, 32'h00000AF0, empty-stack pointer value; must equal the stack pointer register reset value.
- StackLimit, 32'h00000A00, lowest legal stack address.
- WordBytes, 4, stack pointer step per push/pop.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PushReq  input  1  push request, sampled in IDLE.
- PopReq  input  1  pop request, sampled in IDLE.
- PushData  input  Width  word to push, captured when a push is accepted.
- ReqReady  output  1  high only in IDLE.
- Done  output  1  one-cycle completion pulse.
- Error  output  1  valid with Done; high means overflow or underflow, and no memory access or SP change occurred.
- PopData  output  Width  popped word, held until the next successful pop.
- SPCurrent  input  Width  stack pointer register output.
- SPWrite  output  1  stack pointer register enable, one-cycle pulse.
- SPNext  output  Width  stack pointer register data input.
- MemAddr  output  Width  memory address.
- MemWData  output  Width  memory write data.
- MemWrite  output  1  write strobe.
- MemRead  output  1  read strobe.
- MemRData  input  Width  memory read data, valid when MemReady=1.
- MemReady  input  1  memory accepts the write / returns read data this cycle.

Behaviour:
- Reset (asynchronous, Reset=0):
  - State=IDLE.
  - Outputs: ReqReady=1; Done, Error, SPWrite, MemWrite, MemRead = 0.
  - SPNext, MemAddr, MemWData, PopData = 0.
  - A reset mid-transaction aborts it immediately with no SPWrite pulse. The stack pointer register is reset separately.
- States: IDLE, PUSH_WR, POP_RD, FINISH.
- IDLE:
  - If PushReq and PopReq are both high, push wins. The pop is not queued; the requester must reassert it.
  - Push:
    - If SPCurrent - WordBytes < StackLimit, or the subtraction wraps below 0: overflow. Go to FINISH with Error=1.
    - Otherwise latch MemAddr = SPCurrent - WordBytes and MemWData = PushData, then go to PUSH_WR.
  - Pop:
    - If SPCurrent >= StackBase: underflow. Go to FINISH with Error=1.
    - Otherwise latch MemAddr = SPCurrent and SPNext = SPCurrent + WordBytes, then go to POP_RD.
- PUSH_WR:
  - MemWrite=1 is held, with stable MemAddr and MemWData, until MemReady=1.
  - In the MemReady cycle: SPNext = MemAddr and SPWrite pulses for the next cycle; go to FINISH.
- POP_RD:
  - MemRead=1 is held until MemReady=1.
  - In the MemReady cycle: PopData <= MemRData, then SPWrite pulses; go to FINISH.
- FINISH:
  - Done=1 for exactly one cycle; Error is valid in the same cycle. Return to IDLE.
  - SPWrite and Done are asserted in the same cycle (FINISH).
- Latency with zero-wait memory: request edge to Done is 3 cycles (IDLE → access → FINISH). Each wait cycle adds one. An error completes in 2 cycles.
- Requests outside IDLE are ignored.
- SPCurrent is sampled only in IDLE. The stack pointer register must not be written by anyone else while ReqReady=0.
- Memory strobes are never both high.

Optional Feature:
- Macro STACK_WATERMARK_EN.
- When defined:
  - Adds output MinSP [Width-1:0], reset value StackBase.
  - On every successful push completion, MinSP <= min(MinSP, new SP).
  - Adds output DepthMax: (StackBase - MinSP) / WordBytes.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Push 32'hDEADBEEF with SPCurrent=32'h00000AF0, MemReady tied 1 -> MemWrite at addr 32'h00000AEC with data 32'hDEADBEEF; SPWrite with SPNext=32'h00000AEC; Done 3 cycles after the request edge; Error=0.
- Pop with SPCurrent=32'h00000AEC, MemRData=32'h12345678, MemReady delayed 2 cycles -> MemRead held 3 cycles; PopData=32'h12345678; SPNext=32'h00000AF0; Done at cycle 5.
- Pop with SPCurrent=32'h00000AF0 -> Done+Error after 2 cycles; no MemRead, no SPWrite; PopData unchanged.
- Push with SPCurrent=32'h00000A00 -> overflow Done+Error; no MemWrite. Push with SPCurrent=32'h00000A04 -> succeeds at addr 32'h00000A00.
- PushReq and PopReq both high in IDLE -> push only executes, pop is dropped. Reset=0 asserted during PUSH_WR wait -> MemWrite drops asynchronously, no SPWrite, ReqReady=1.
- STACK_WATERMARK_EN defined: 3 pushes then 2 pops from 32'h00000AF0 -> MinSP=32'h00000AE4, DepthMax=3.
